modlift: RTL and testbench

- Sequential reconstruction unit for the prime-field ECC datapath.
- Performs the inverse of the signed modular reduction: takes a floor quotient q, a canonical residue r and a modulus p, and rebuilds the signed integer value = q*p + r.
- The multiply is a serial shift-add over the magnitude bits of p, so the block costs one adder, not a multiplier array.
- Sits downstream of the reducer. It is used to cross-check reduced coordinates and to re-expand residues into signed operands for the next arithmetic stage.

---
 rtl/modlift_if.sv | 23 ++
 rtl/modlift.sv | 114 +++++++++++
 tb/tb_modlift.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/modlift_if.sv
// Operand/result handshake bundle for modlift: the upstream drives q/r/p with in_valid,
// the downstream accepts result/err with out_ready.
interface modlift_if;
    logic                in_valid;
    logic                in_ready;
    logic signed [7:0]   q;
    logic        [5:0]   r;
    logic signed [4:0]   p;
    logic                out_valid;
    logic                out_ready;
    logic signed [11:0]  result;
    logic                err;

    modport master (
        output in_valid, q, r, p, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, q, r, p, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/modlift.sv
// Serial reconstruction of value = q*p + r using one shift-add adder over the 4 magnitude bits of p.
// Optional operand range check is enabled by defining MODLIFT_RANGE_CHECK_EN.
module modlift (
    input  logic      clk,
    input  logic      rst,
    modlift_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t              state, state_nxt;
    logic signed [11:0]  acc;
    logic signed [11:0]  qx;
    logic        [5:0]   rr;
    logic        [3:0]   pp;
    logic        [1:0]   cnt;
    logic                accept;
    logic                bad;
    logic                in_ready_c;
    logic                out_valid_c;

`ifdef MODLIFT_RANGE_CHECK_EN
    logic err_q;

    assign bad     = bus.p[4] || (bus.p[3:0] == 4'd0) || (bus.r >= {2'b00, bus.p[3:0]});
    assign bus.err = err_q;
`else
    logic p_sign_unused;

    assign bad           = 1'b0;
    assign p_sign_unused = bus.p[4];
    assign bus.err       = 1'b0;
`endif

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (accept) begin
                    state_nxt = bad ? DONE : MUL;
                end
            end
            MUL: begin
                if (cnt == 2'd3) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are latched only at acceptance; acc is the only value visible on result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
`ifdef MODLIFT_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        qx  <= {{4{bus.q[7]}}, bus.q};
                        rr  <= bus.r;
                        pp  <= bus.p[3:0];
                        acc <= '0;
                        cnt <= '0;
`ifdef MODLIFT_RANGE_CHECK_EN
                        err_q <= bad;
`endif
                    end
                end
                MUL: begin
                    if (pp[cnt]) begin
                        acc <= acc + (qx <<< cnt);
                    end
                    cnt <= cnt + 2'd1;
                end
                ADD: begin
                    acc <= acc + $signed({6'b000000, rr});
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modlift.sv
// Directed self-checking bench for modlift: latency, extremes, backpressure, reset abort, range check.
module tb_modlift;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   lat;

    modlift_if bus ();

    modlift dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Present an operand set and return at the falling edge right after the acceptance edge.
    task automatic accept_op(input logic signed [7:0] qv, input logic [5:0] rv, input logic signed [4:0] pv);
        @(negedge clk);
        bus.q        = qv;
        bus.r        = rv;
        bus.p        = pv;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
        n_assert++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count falling edges after the acceptance edge until out_valid shows, bounded.
    task automatic wait_out(output int l);
        l = 0;
        while (!bus.out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        n_assert++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        n_assert++;
        if (bus.result !== 12'sd0) begin n_fail++; $display("FAIL reset_result: got %0d required 0", bus.result); end
        n_assert++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_mid_range();
        logic signed [11:0] e;
        e = -12'sd19;
        accept_op(-8'sd3, 6'd2, 5'sd7);
        wait_out(lat);
        n_assert++;
        if (lat !== 5) begin n_fail++; $display("FAIL mid_latency: got %0d required 5", lat); end
        n_assert++;
        if (bus.result !== e) begin n_fail++; $display("FAIL mid_result: got %0d required %0d", bus.result, e); end
        n_assert++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b required 0", bus.err); end
        consume();
    endtask

    task automatic test_extremes();
        logic signed [11:0] e;
        e = 12'sd1919;
        accept_op(8'sd127, 6'd14, 5'sd15);
        wait_out(lat);
        n_assert++;
        if (bus.out_valid !== 1'b1 || bus.result !== e) begin
            n_fail++; $display("FAIL pos_extreme: got %0d valid %b required %0d", bus.result, bus.out_valid, e);
        end
        consume();
        e = -12'sd1920;
        accept_op(-8'sd128, 6'd0, 5'sd15);
        wait_out(lat);
        n_assert++;
        if (bus.out_valid !== 1'b1 || bus.result !== e) begin
            n_fail++; $display("FAIL neg_extreme: got %0d valid %b required %0d", bus.result, bus.out_valid, e);
        end
        consume();
    endtask

    task automatic test_min_modulus();
        accept_op(8'sd0, 6'd0, 5'sd1);
        wait_out(lat);
        n_assert++;
        if (bus.out_valid !== 1'b1 || bus.result !== 12'sd0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL min_modulus: got %0d err %b valid %b required 0 err 0 valid 1", bus.result, bus.err, bus.out_valid);
        end
        consume();
    endtask

    task automatic test_backpressure();
        accept_op(8'sd5, 6'd1, 5'sd3);
        wait_out(lat);
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b required 1", i, bus.out_valid); end
            n_assert++;
            if (bus.result !== 12'sd16) begin n_fail++; $display("FAIL bp_result_%0d: got %0d required 16", i, bus.result); end
            n_assert++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b required 0", i, bus.in_ready); end
            if (i == 1) begin
                bus.q = 8'sd9; bus.r = 6'd1; bus.p = 5'sd2; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_assert++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_handshake: got %b required 0", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_assert++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_after_handshake: in_ready %b out_valid %b required 1 0", bus.in_ready, bus.out_valid);
        end
        // The pulse seen during DONE must not have started a hidden operation.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_assert++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ghost_op_%0d: out_valid %b required 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        accept_op(8'sd100, 6'd3, 5'sd15);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_assert++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 12'sd0) begin
            n_fail++; $display("FAIL reset_mid: in_ready %b out_valid %b result %0d required 1 0 0", bus.in_ready, bus.out_valid, bus.result);
        end
        accept_op(8'sd2, 6'd3, 5'sd5);
        wait_out(lat);
        n_assert++;
        if (lat !== 5 || bus.result !== 12'sd13) begin
            n_fail++; $display("FAIL after_reset_op: result %0d latency %0d required 13 latency 5", bus.result, lat);
        end
        consume();
    endtask

    task automatic test_range_check();
`ifdef MODLIFT_RANGE_CHECK_EN
        accept_op(8'sd4, 6'd9, 5'sd7);
        wait_out(lat);
        n_assert++;
        if (lat !== 0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL range_latency: got %0d required 0 extra edges", lat); end
        n_assert++;
        if (bus.result !== 12'sd0 || bus.err !== 1'b1) begin
            n_fail++; $display("FAIL range_flag: result %0d err %b required 0 1", bus.result, bus.err);
        end
        consume();
        accept_op(8'sd4, 6'd0, 5'sd0);
        wait_out(lat);
        n_assert++;
        if (lat !== 0 || bus.err !== 1'b1 || bus.result !== 12'sd0) begin
            n_fail++; $display("FAIL range_p_zero: result %0d err %b latency %0d required 0 1 0", bus.result, bus.err, lat);
        end
        consume();
`else
        accept_op(8'sd4, 6'd9, 5'sd7);
        wait_out(lat);
        n_assert++;
        if (lat !== 5 || bus.result !== 12'sd37 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL range_unchecked: result %0d err %b latency %0d required 37 0 5", bus.result, bus.err, lat);
        end
        consume();
`endif
        accept_op(8'sd1, 6'd0, 5'sd1);
        wait_out(lat);
        n_assert++;
        if (bus.result !== 12'sd1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL err_clears: result %0d err %b required 1 0", bus.result, bus.err);
        end
        consume();
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        n_assert      = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.q         = '0;
        bus.r         = '0;
        bus.p         = '0;
        test_reset();
        test_mid_range();
        test_extremes();
        test_min_modulus();
        test_backpressure();
        test_reset_mid();
        test_range_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
